// File: rtl/uart_param_pkg.sv
// rtl/uart_param_pkg.sv - shared FSM state types, oversampling constants and parity helper for uart_param
package uart_param_pkg;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;

  // Callers zero-extend narrower words; the extra zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_param_baud_gen.sv
// rtl/uart_param_baud_gen.sv - free-running divider emitting a one-cycle tick every DIVISOR clocks
module uart_param_baud_gen #(
  parameter int DIVISOR = 27
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIVISOR - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge clk) begin
    if (reset || w_wrap) r_cnt <= '0;
    else                 r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised single-clock UART with 16x oversampled RX and sticky status.
// Optional parity bit in both directions when UART_PARAM_PARITY_EN is defined.
module uart_param
  import uart_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIVISOR    = 27,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_enable,
  output logic              tx_out,
  output logic              tx_empty,
  input  logic              uld_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_enable,
  input  logic              rx_in,
  output logic              rx_empty,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  logic w_tick;

  tx_state_t         r_tx_state, w_tx_next;
  logic [DATA_W-1:0] r_tx_shift;
  logic [3:0]        r_tx_tick, r_tx_bit;
  logic              w_tx_bit_end, w_tx_load, w_tx_out;

  rx_state_t         r_rx_state, w_rx_next;
  logic              r_rx_sync1, r_rx_sync2, r_rx_prev;
  logic [3:0]        r_rx_tick, r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift, r_rx_data;
  logic              r_rx_empty, r_rx_fe, r_rx_ov;
  logic              w_rx_mid, w_rx_sample, w_rx_done, w_rx_accept;

`ifdef UART_PARAM_PARITY_EN
  logic r_tx_par, r_rx_par_bad, r_rx_pe;
`endif

  uart_param_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign w_tx_bit_end = w_tick && (r_tx_tick == 4'(OVERSAMPLE - 1));
  assign w_tx_load    = ld_tx_data && tx_enable && (r_tx_state == TX_IDLE);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_out  = 1'b1;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_load) w_tx_next = TX_START;
      TX_START: begin
        w_tx_out = 1'b0;
        if (w_tx_bit_end) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx_out = r_tx_shift[0];
        if (w_tx_bit_end && (r_tx_bit == 4'(DATA_W - 1)))
`ifdef UART_PARAM_PARITY_EN
          w_tx_next = TX_PARITY;
`else
          w_tx_next = TX_STOP;
`endif
      end
`ifdef UART_PARAM_PARITY_EN
      TX_PARITY: begin
        w_tx_out = r_tx_par;
        if (w_tx_bit_end) w_tx_next = TX_STOP;
      end
`endif
      TX_STOP:  if (w_tx_bit_end && (r_tx_bit == 4'(STOP_BITS - 1))) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // Tick and bit counters restart on every state change and otherwise wrap per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_load)                                r_tx_shift <= tx_data;
      else if (r_tx_state == TX_DATA && w_tx_bit_end) r_tx_shift <= r_tx_shift >> 1;
      if (w_tx_next != r_tx_state) r_tx_tick <= '0;
      else if (w_tick)             r_tx_tick <= r_tx_tick + 1'b1;
      if (w_tx_next != r_tx_state) r_tx_bit <= '0;
      else if (w_tx_bit_end)       r_tx_bit <= r_tx_bit + 1'b1;
    end
  end

  assign tx_out   = w_tx_out;
  assign tx_empty = (r_tx_state == TX_IDLE);

  assign w_rx_mid    = w_tick && (r_rx_tick == 4'(MID_TICK - 1));
  assign w_rx_sample = w_tick && (r_rx_tick == 4'(OVERSAMPLE - 1));

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync2) w_rx_next = RX_START;
      RX_START: if (w_rx_mid) w_rx_next = r_rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (w_rx_sample && (r_rx_bit == 4'(DATA_W - 1)))
`ifdef UART_PARAM_PARITY_EN
          w_rx_next = RX_PARITY;
`else
          w_rx_next = RX_STOP;
`endif
`ifdef UART_PARAM_PARITY_EN
      RX_PARITY: if (w_rx_sample) w_rx_next = RX_STOP;
`endif
      RX_STOP: if (w_rx_sample) begin
        w_rx_next = RX_IDLE;
        w_rx_done = 1'b1;
      end
      default: w_rx_next = RX_IDLE;
    endcase
    if (!rx_enable) begin
      w_rx_next = RX_IDLE;
      w_rx_done = 1'b0;
    end
  end

  // A completion coinciding with an unload is taken as a fresh word, not an overrun.
  assign w_rx_accept = w_rx_done && (r_rx_empty || uld_rx_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_empty <= 1'b1;
      r_rx_fe    <= 1'b0;
      r_rx_ov    <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_sync1 <= rx_in;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
      if (w_rx_next != r_rx_state) r_rx_tick <= '0;
      else if (w_tick)             r_rx_tick <= r_rx_tick + 1'b1;
      if (w_rx_next != r_rx_state) r_rx_bit <= '0;
      else if (w_rx_sample)        r_rx_bit <= r_rx_bit + 1'b1;
      if (r_rx_state == RX_DATA && w_rx_sample)
        r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_W-1:1]};
      if (w_rx_accept) begin
        r_rx_data  <= r_rx_shift;
        r_rx_empty <= 1'b0;
        r_rx_fe    <= (r_rx_fe & ~uld_rx_data) | ~r_rx_sync2;
        r_rx_ov    <= r_rx_ov & ~uld_rx_data;
      end else if (w_rx_done) begin
        r_rx_ov <= 1'b1;
      end else if (uld_rx_data) begin
        r_rx_empty <= 1'b1;
        r_rx_fe    <= 1'b0;
        r_rx_ov    <= 1'b0;
      end
    end
  end

`ifdef UART_PARAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_par     <= 1'b0;
      r_rx_par_bad <= 1'b0;
      r_rx_pe      <= 1'b0;
    end else begin
      if (w_tx_load) r_tx_par <= calc_parity(9'(tx_data), PARITY_ODD);
      if (r_rx_state == RX_PARITY && w_rx_sample)
        r_rx_par_bad <= calc_parity(9'(r_rx_shift), PARITY_ODD) ^ r_rx_sync2;
      if (w_rx_accept)                   r_rx_pe <= (r_rx_pe & ~uld_rx_data) | r_rx_par_bad;
      else if (!w_rx_done && uld_rx_data) r_rx_pe <= 1'b0;
    end
  end
  assign rx_parity_err = r_rx_pe;
`else
  assign rx_parity_err = PARITY_ODD & 1'b0;
`endif

  assign rx_data      = r_rx_data;
  assign rx_empty     = r_rx_empty;
  assign rx_frame_err = r_rx_fe;
  assign rx_overrun   = r_rx_ov;

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - randomized self-checking bench for uart_param against a frame-level reference model
module tb_uart_param;

`ifdef UART_PARAM_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int BIT0 = 64;
  localparam int BIT9 = 32;
  localparam int NB0  = 1 + 8 + PEN + 1;
  localparam int NB9  = 1 + 9 + PEN + 2;

  logic clk = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset, ld, tx_en, uld, rx_en, r_loop, r_drv;
  logic [7:0] txd, rx_data;
  logic       tx_out, tx_empty, rx_empty, fe, pe, ov;
  logic       w_rx_in;
  assign w_rx_in = r_loop ? tx_out : r_drv;

  logic       reset9, ld9;
  logic [8:0] txd9, rx_data9;
  logic       tx_out9, tx_empty9, rx_empty9, fe9, pe9, ov9;

  uart_param #(.DATA_W(8), .STOP_BITS(1), .DIVISOR(4), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .reset(reset), .ld_tx_data(ld), .tx_data(txd), .tx_enable(tx_en),
    .tx_out(tx_out), .tx_empty(tx_empty), .uld_rx_data(uld), .rx_data(rx_data),
    .rx_enable(rx_en), .rx_in(w_rx_in), .rx_empty(rx_empty), .rx_frame_err(fe),
    .rx_parity_err(pe), .rx_overrun(ov)
  );

  uart_param #(.DATA_W(9), .STOP_BITS(2), .DIVISOR(2), .PARITY_ODD(1'b0)) u_dut9 (
    .clk(clk), .reset(reset9), .ld_tx_data(ld9), .tx_data(txd9), .tx_enable(1'b1),
    .tx_out(tx_out9), .tx_empty(tx_empty9), .uld_rx_data(1'b0), .rx_data(rx_data9),
    .rx_enable(1'b0), .rx_in(1'b1), .rx_empty(rx_empty9), .rx_frame_err(fe9),
    .rx_parity_err(pe9), .rx_overrun(ov9)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of the receive-side status registers.
  logic       m_empty, m_fe, m_pe, m_ov;
  logic [7:0] m_data;

  task automatic model_frame(input logic [7:0] d, input logic bad_stop, input logic bad_par);
    if (m_empty) begin
      m_data  = d;
      m_empty = 1'b0;
      m_fe    = m_fe | bad_stop;
      m_pe    = m_pe | bad_par;
    end else begin
      m_ov = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_rx_empty"}, rx_empty, m_empty);
    chk({tag, "_rx_data"},  rx_data,  m_data);
    chk({tag, "_frame"},    fe,       m_fe);
    chk({tag, "_parity"},   pe,       m_pe);
    chk({tag, "_overrun"},  ov,       m_ov);
  endtask

  task automatic unload();
    @(negedge clk); uld = 1'b1;
    @(negedge clk); uld = 1'b0;
    m_empty = 1'b1; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [8:0] d, input int w, input int k);
    if (k == 0) return 1'b0;
    if (k <= w) return d[k-1];
    if (PEN && k == w + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic drive_bit(input logic b);
    @(negedge clk); r_drv = b;
    repeat (BIT0 - 1) @(negedge clk);
  endtask

  task automatic recv_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PEN) drive_bit(par);
    drive_bit(stop);
    @(negedge clk); r_drv = 1'b1;
    repeat (BIT0) @(negedge clk);
    model_frame(d, ~stop, PEN && (par != ^d));
  endtask

  logic [7:0] d;
  logic [8:0] d9;
  int         t0, lat;

  initial begin
    reset = 1'b1; reset9 = 1'b1; ld = 1'b0; ld9 = 1'b0; uld = 1'b0;
    tx_en = 1'b1; rx_en = 1'b1; r_loop = 1'b0; r_drv = 1'b1;
    txd = '0; txd9 = '0;
    m_empty = 1'b1; m_data = '0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset9 = 1'b0;
    @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_empty", tx_empty, 1);
    check_status("rst");

    // Loopback with random words; a second load mid-frame must be ignored.
    r_loop = 1'b1;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      @(negedge clk); txd = d; ld = 1'b1;
      @(negedge clk); ld = 1'b0; t0 = cyc;
      chk("tx_start_low", tx_out, 0);
      chk("tx_busy", tx_empty, 0);
      for (int k = 0; k < NB0; k++) begin
        while (cyc < t0 + k * BIT0 + BIT0 / 2) @(negedge clk);
        chk($sformatf("tx_bit%0d", k), tx_out, frame_bit({1'b0, d}, 8, k));
        if (k == 2) begin
          txd = ~d; ld = 1'b1; @(negedge clk); ld = 1'b0;
        end
      end
      while (rx_empty && cyc < t0 + 2 * NB0 * BIT0) @(negedge clk);
      lat = cyc - t0;
      chk("rx_latency_ok", (lat >= NB0 * BIT0 - BIT0 / 2 - 8) && (lat <= NB0 * BIT0 - BIT0 / 2 + 12), 1);
      model_frame(d, 1'b0, 1'b0);
      check_status("loop");
      while (!tx_empty && cyc < t0 + 2 * NB0 * BIT0) @(negedge clk);
      lat = cyc - t0;
      chk("tx_frame_len_ok", (lat >= NB0 * BIT0 - 6) && (lat <= NB0 * BIT0 + 2), 1);
      unload();
      check_status("loop_uld");
    end

    @(negedge clk); tx_en = 1'b0; txd = 8'h3C; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
    chk("tx_dis_empty", tx_empty, 1);
    chk("tx_dis_out", tx_out, 1);
    tx_en = 1'b1;
    r_loop = 1'b0;
    repeat (BIT0) @(negedge clk);

    // Wrong parity bit for 0x03 (flags only when parity is built in).
    recv_frame(8'h03, 1'b1, 1'b1);
    check_status("par");
    unload();
    check_status("par_uld");

    recv_frame(8'h5A, ^8'h5A, 1'b0);
    check_status("frm");
    unload();
    check_status("frm_uld");

    recv_frame(8'h11, ^8'h11, 1'b1);
    recv_frame(8'h22, ^8'h22, 1'b1);
    check_status("ovr");
    unload();
    check_status("ovr_uld");

    @(negedge clk); r_drv = 1'b0;
    repeat (16) @(negedge clk);
    r_drv = 1'b1;
    repeat (4 * BIT0) @(negedge clk);
    check_status("glitch");
    d = 8'($urandom_range(0, 255));
    recv_frame(d, ^d, 1'b1);
    check_status("after_glitch");
    unload();

    // Disable the receiver mid-frame: the partial frame must vanish.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk); rx_en = 1'b0; r_drv = 1'b1;
    repeat (4) @(negedge clk);
    rx_en = 1'b1;
    repeat (NB0 * BIT0) @(negedge clk);
    check_status("rx_dis");

    // Reset mid-frame on the 9-bit, 2-stop instance, then a full frame and back-to-back load.
    @(negedge clk); txd9 = 9'h0FF; ld9 = 1'b1;
    @(negedge clk); ld9 = 1'b0;
    repeat (4 * BIT9) @(negedge clk);
    chk("r9_busy", tx_empty9, 0);
    reset9 = 1'b1;
    @(negedge clk); reset9 = 1'b0;
    chk("r9_reset_out", tx_out9, 1);
    chk("r9_reset_empty", tx_empty9, 1);
    d9 = 9'h0FF;
    @(negedge clk); txd9 = d9; ld9 = 1'b1;
    @(negedge clk); ld9 = 1'b0; t0 = cyc;
    for (int k = 0; k < NB9; k++) begin
      while (cyc < t0 + k * BIT9 + BIT9 / 2) @(negedge clk);
      chk($sformatf("r9_bit%0d", k), tx_out9, frame_bit(d9, 9, k));
    end
    ld9 = 1'b1;
    chk("r9_still_busy", tx_empty9, 0);
    while (!tx_empty9 && cyc < t0 + 2 * NB9 * BIT9) @(negedge clk);
    lat = cyc - t0;
    chk("r9_frame_len_ok", (lat >= NB9 * BIT9 - 4) && (lat <= NB9 * BIT9 + 2), 1);
    @(negedge clk); ld9 = 1'b0;
    chk("b2b_start", tx_out9, 0);
    chk("b2b_busy", tx_empty9, 0);
    chk("r9_rx_quiet", {rx_data9, fe9, pe9, ov9, rx_empty9}, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised single-clock UART: transmitter and receiver with configurable data width, stop-bit count and baud divisor, 16x-oversampled mid-bit receive sampling, an optional parity bit, and sticky framing/parity/overrun status. It replaces the fixed 8-bit dual-clock UART in the serial subsystem. It keeps the same load/unload handshake (`ld_tx_data`/`tx_empty`, `uld_rx_data`/`rx_empty`), so existing host logic ports over with only the clock change.

## Interface
- `DATA_W`, 8, data bits per frame, legal 5..9
- `STOP_BITS`, 1, stop bits per frame, 1 or 2
- `DIVISOR`, 27, clk cycles per oversample tick (≥1); bit period = 16*DIVISOR clk
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd; only used with `UART_PARAM_PARITY_EN`

Ports:
- `clk` in 1: single clock for TX, RX and baud generation
- `reset` in 1: synchronous, active-high
- `ld_tx_data` in 1: load `tx_data`; accepted only when `tx_empty`=1 and `tx_enable`=1
- `tx_data` in DATA_W: transmit word
- `tx_enable` in 1: transmitter enable
- `tx_out` out 1: serial output, idle high
- `tx_empty` out 1: transmitter idle, ready for a load
- `uld_rx_data` in 1: unload the received word and clear the status flags
- `rx_data` out DATA_W: last received word
- `rx_enable` in 1: receiver enable
- `rx_in` in 1: asynchronous serial input
- `rx_empty` out 1: no unread word held
- `rx_frame_err` out 1: sticky; stop bit sampled low
- `rx_parity_err` out 1: sticky; parity mismatch (0 when parity is compiled out)
- `rx_overrun` out 1: sticky; a frame completed while `rx_empty`=0

## Operation
- Reset values: `tx_out`=1, `tx_empty`=1, `rx_empty`=1, `rx_data`=0, all error flags 0. Both FSMs go to IDLE and the tick divider goes to 0.
- Tick divider: free-running; one-cycle `tick` pulse every DIVISOR clk cycles. Every bit lasts 16 ticks.
- TX FSM: IDLE → START → DATA (DATA_W bits, LSB first) → [PARITY] → STOP (STOP_BITS bits) → IDLE.
  - A load latches `tx_data` and sets `tx_empty`=0 on the next cycle.
  - A load while busy, or while `tx_enable`=0, is ignored.
  - Deasserting `tx_enable` mid-frame lets the current frame complete.
- RX path: `rx_in` passes through a 2-flop synchronizer before use.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronized falling edge enters START and resets the tick count.
  - START: sample after 8 ticks; if high (glitch), return to IDLE with no status change.
  - Each following bit is sampled at tick 16 of its bit period (mid-bit). Only the first stop bit is checked.
- RX frame completion:
  - If `rx_empty`=1: write `rx_data`, set `rx_empty`=0, and OR in `rx_frame_err`/`rx_parity_err`.
  - If `rx_empty`=0: discard the word, set `rx_overrun`=1, and leave `rx_data` unchanged.
- `uld_rx_data` sets `rx_empty`=1 and clears all three error flags on the next cycle.
  - If it coincides with a frame completion, the completion wins: the new word is written, `rx_empty`=0, and no overrun is flagged.
- Deasserting `rx_enable` forces the RX FSM to IDLE the same cycle. A partial frame is dropped and held data and flags are untouched.
- A `reset` assertion mid-frame aborts both directions. `tx_out`=1 on the next cycle.

## Timing
- TX: `ld_tx_data` at cycle N → `tx_out` falls at N+1. The frame lasts (1+DATA_W+P+STOP_BITS)*16*DIVISOR cycles, where P = 1 with parity, else 0. `tx_empty` rises the cycle after the last stop bit ends.
- RX: `rx_empty` falls at the mid-point of the first stop bit, plus 2 cycles of synchronizer latency.
- Back-to-back TX: a load on the same cycle `tx_empty` rises starts the next start bit with no idle gap.

## Configuration
- Macro `UART_PARAM_PARITY_EN`.
- Defined: a PARITY state is inserted after DATA in both FSMs.
  - TX sends XOR(data)^PARITY_ODD.
  - RX compares the received bit against the same value and flags `rx_parity_err` on mismatch.
- Undefined: no PARITY state, `rx_parity_err` is tied to 0, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_param_pkg` holds:
  - enum types `tx_state_t` and `rx_state_t`
  - constant `OVERSAMPLE`=16 and mid-sample constant `MID_TICK`=8
  - function `calc_parity(data, odd)`
- Sub-module `uart_param_baud_gen`: divider producing `tick`. A single instance is shared by TX and RX.

## Test plan
- Loopback: `tx_out`→`rx_in`, DATA_W=8, DIVISOR=4, send 0xA5 → `rx_data`=0xA5, `rx_empty`=0 about 608 cycles after the load, no error flags.
- Parity: with `UART_PARAM_PARITY_EN`, even parity, drive 0x03 with parity bit 1 → `rx_parity_err`=1 and `rx_data`=0x03.
- Framing: drive 0x5A with the stop bit held low → `rx_frame_err`=1. A following `uld_rx_data` clears it and sets `rx_empty`=1.
- Overrun: receive 0x11 then 0x22 without unloading → `rx_overrun`=1 and `rx_data`=0x11.
- False start: pulse `rx_in` low for 4 ticks → RX returns to IDLE, `rx_empty` stays 1, no flags set.
- Reset mid-frame: assert `reset` during the DATA bits of a TX frame of 0xFF with DATA_W=9, STOP_BITS=2 → next cycle `tx_out`=1 and `tx_empty`=1; the next load sends a complete frame.
